// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_pkg                                                       |
// | Description : Shared types and constants for the multi-cycle MIPS          |
// |               controller: state encoding, opcode/funct values, mux-select  |
// |               encodings and the per-state control decode.                  |
// |               Optional feature macro: MULTICYCLE_JUMP_LINK_EN              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mc_pkg;

  // Explicit encodings so the debug state port is stable across builds.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC     = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
`ifdef MULTICYCLE_JUMP_LINK_EN
    JAL      = 4'd11,
    JR       = 4'd12,
`endif
    ILLEGAL  = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [5:0] ALUOP_ADD = 6'b000000;
  localparam logic [5:0] ALUOP_SUB = 6'b000100;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  // Registered control word; IRWrite and the fetch PCWrite are handled
  // outside because they are gated by mem_ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [5:0] alu_op;
    logic       illegal_op;
  } ctl_t;

  // Moore decode: control word for a state given the latched opcode.
  function automatic ctl_t ctl_decode(input state_e st, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = MEMTOREG_MDR;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = op;
        c.alu_src_b = (op == OP_RTYPE) ? SRCB_B : SRCB_IMM;
      end
      ALU_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = MEMTOREG_ALUOUT;
        c.reg_dst    = (op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_JUMP_LINK_EN
      JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.reg_write  = 1'b1;
        c.reg_dst    = REGDST_RA;
        c.mem_to_reg = MEMTOREG_PC;
      end
      JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_REG;
      end
`endif
      ILLEGAL: begin
        c.illegal_op = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control_if                                        |
// | Description : Controller <-> datapath bundle: IR fields, ALU flag, memory  |
// |               handshake, all mux selects and write enables.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface multicycle_control_if #(
  parameter int ALUOP_W = 6
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;

  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         MemtoReg;
  logic [1:0]         RegDst;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic               illegal_op;
  logic [3:0]         state;

  // Controller side.
  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp, illegal_op, state
  );

  // Datapath side.
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp, illegal_op, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_dispatch                                                  |
// | Description : Opcode/funct lookup selecting the state that follows DECODE. |
// |               Optional feature macro: MULTICYCLE_JUMP_LINK_EN              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_dispatch
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_e     next_state
);

`ifndef MULTICYCLE_JUMP_LINK_EN
  // Without jr support the funct field has no bearing on dispatch.
  logic unused_funct;
  assign unused_funct = ^funct;
`endif

  // Map the instruction class to its first post-decode state.
  always_comb begin
    next_state = ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
`ifdef MULTICYCLE_JUMP_LINK_EN
        next_state = (funct == FUNCT_JR) ? JR : EXEC;
`else
        next_state = EXEC;
`endif
      end
      OP_LW, OP_SW:     next_state = MEM_ADDR;
      OP_ADDI, OP_ANDI: next_state = EXEC;
      OP_BEQ:           next_state = BRANCH;
      OP_J:             next_state = JUMP;
`ifdef MULTICYCLE_JUMP_LINK_EN
      OP_JAL:           next_state = JAL;
`endif
      default:          next_state = ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control                                           |
// | Description : Moore FSM sequencing the multi-cycle MIPS datapath through   |
// |               fetch/decode/execute/memory/write-back with a memory ready   |
// |               stall. Control outputs are registered from the next state.   |
// |               Optional feature macro: MULTICYCLE_JUMP_LINK_EN              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_control
  import mc_pkg::*;
#(
  parameter int ALUOP_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_e     state_q;
  state_e     state_d;
  state_e     dispatch_st;
  logic [5:0] op_q;
  logic [5:0] op_d;
  ctl_t       ctl_q;
  logic       fetch_done;

  // The ALU zero flag is consumed by the datapath through PCWriteCond.
  logic unused_zero;
  assign unused_zero = bus.zero;

  mc_dispatch u_dispatch (
    .opcode     (bus.opcode),
    .funct      (bus.funct),
    .next_state (dispatch_st)
  );

  // Opcode is captured while in DECODE and held for the rest of the instruction.
  always_comb begin
    op_d = (state_q == DECODE) ? bus.opcode : op_q;
  end

  // Next-state selection; mem_ready only matters in the memory-access states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE:   state_d = dispatch_st;
      MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (bus.mem_ready) state_d = MEM_WB;
      MEM_WR:   if (bus.mem_ready) state_d = FETCH;
      EXEC:     state_d = ALU_WB;
      default:  state_d = FETCH;
    endcase
  end

  // State, latched opcode and control word; async reset drops all outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctl_q   <= ctl_decode(state_d, op_d);
    end
  end

  // IR load and PC+4 happen only in the cycle the instruction word arrives.
  assign fetch_done = (state_q == FETCH) && bus.mem_ready;

  assign bus.PCWrite     = ctl_q.pc_write | fetch_done;
  assign bus.IRWrite     = fetch_done;
  assign bus.PCWriteCond = ctl_q.pc_write_cond;
  assign bus.IorD        = ctl_q.iord;
  assign bus.MemRead     = ctl_q.mem_read;
  assign bus.MemWrite    = ctl_q.mem_write;
  assign bus.RegWrite    = ctl_q.reg_write;
  assign bus.ALUSrcA     = ctl_q.alu_src_a;
  assign bus.MemtoReg    = ctl_q.mem_to_reg;
  assign bus.RegDst      = ctl_q.reg_dst;
  assign bus.ALUSrcB     = ctl_q.alu_src_b;
  assign bus.PCSource    = ctl_q.pc_source;
  assign bus.ALUOp       = ALUOP_W'(ctl_q.alu_op);
  assign bus.illegal_op  = ctl_q.illegal_op;
  assign bus.state       = state_q;

endmodule
`default_nettype wire
